ahb_lite_slave_mux: RTL

Parametrised single-master AHB-lite address decoder and response multiplexer for N_SLAVE slaves. It replaces fixed per-slave wiring at the system top. It drives per-slave HSEL from a base/mask address map and registers the data-phase owner. It returns the selected slave's HREADY, HRESP and HRDATA to the master, and contains a built-in default slave that answers unmapped accesses with a two-cycle AHB ERROR response and logs each one.

---
 rtl/ahb_lite_slave_mux.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_slave_mux.sv
// ---------------------------------------------------------------------------
// ahb_lite_slave_mux
//
// Single-master AHB-lite address decoder and response multiplexer for
// N_SLAVE slaves. Each slave is selected from a base/mask address map, the
// owner of the data phase is registered, and that owner's HREADY/HRESP/HRDATA
// are returned to the master. Accesses that hit no slave are answered by a
// built-in default slave with a two-cycle ERROR response. Each of these
// accesses is logged in a saturating counter, together with its address.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   ma_H*                master address/control/write-data inputs
//   out_ma_HREADY/HRESP/HRDATA   response returned to the master
//   out_sl_HSEL          one-hot (or zero) per-slave select
//   out_sl_H*            unregistered broadcast copies of the master signals
//   out_sl_HREADY        broadcast HREADY, identical to out_ma_HREADY
//   sl_HREADY/HRESP/HRDATA       per-slave responses, packed by slave index
//   err_clr              synchronous clear of the error counter
//   err_cnt, err_addr    unmapped-access count and most recent address
// ---------------------------------------------------------------------------
module ahb_lite_slave_mux #(
  parameter int N_SLAVE  = 4,
  parameter int W_ADDR   = 32,
  parameter int W_DATA   = 32,
  parameter logic [N_SLAVE*W_ADDR-1:0] ADDR_BASE_MAP =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLAVE*W_ADDR-1:0] ADDR_MASK_MAP = {4{32'hF000_0000}},
  parameter int W_ERRCNT = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [W_ADDR-1:0]       ma_HADDR,
  input  logic [1:0]              ma_HTRANS,
  input  logic                    ma_HWRITE,
  input  logic [2:0]              ma_HSIZE,
  input  logic [2:0]              ma_HBURST,
  input  logic [W_DATA-1:0]       ma_HWDATA,
  output logic                    out_ma_HREADY,
  output logic [1:0]              out_ma_HRESP,
  output logic [W_DATA-1:0]       out_ma_HRDATA,
  output logic [N_SLAVE-1:0]      out_sl_HSEL,
  output logic [W_ADDR-1:0]       out_sl_HADDR,
  output logic [1:0]              out_sl_HTRANS,
  output logic                    out_sl_HWRITE,
  output logic [2:0]              out_sl_HSIZE,
  output logic [2:0]              out_sl_HBURST,
  output logic [W_DATA-1:0]       out_sl_HWDATA,
  output logic                    out_sl_HREADY,
  input  logic [N_SLAVE-1:0]      sl_HREADY,
  input  logic [N_SLAVE*2-1:0]    sl_HRESP,
  input  logic [N_SLAVE*W_DATA-1:0] sl_HRDATA,
  input  logic                    err_clr,
  output logic [W_ERRCNT-1:0]     err_cnt,
  output logic [W_ADDR-1:0]       err_addr
);

  localparam int IDX_W = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

  // Kind of owner for an address or data phase
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_SLV  = 2'd1;
  localparam logic [1:0] K_DEF  = 2'd2;

  // Default-slave FSM states
  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_ERR1 = 2'd1;
  localparam logic [1:0] D_ERR2 = 2'd2;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  logic              active;
  logic              hitAny;
  logic [IDX_W-1:0]  winIdx;
  logic [1:0]        addrKind;

  logic [1:0]        dpKind_q, dpKind_d;
  logic [IDX_W-1:0]  dpIdx_q, dpIdx_d;
  logic [1:0]        defState_q, defState_d;
  logic [W_ERRCNT-1:0] errCnt_q, errCnt_d;
  logic [W_ADDR-1:0] errAddr_q, errAddr_d;

  logic              rspReady;
  logic [1:0]        rspResp;
  logic [W_DATA-1:0] rspData;
  logic              loadDef;

  assign active = ma_HTRANS[1];

  // The scan runs from the top index downwards, so the last match written is
  // the lowest index and overlapping map entries resolve in its favour.
  always_comb begin
    hitAny = 1'b0;
    winIdx = '0;
    for (int i = N_SLAVE - 1; i >= 0; i--) begin
      if ((ma_HADDR & ADDR_MASK_MAP[i*W_ADDR +: W_ADDR]) ==
          (ADDR_BASE_MAP[i*W_ADDR +: W_ADDR] & ADDR_MASK_MAP[i*W_ADDR +: W_ADDR])) begin
        hitAny = 1'b1;
        winIdx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    if (!active) begin
      addrKind = K_NONE;
    end else if (hitAny) begin
      addrKind = K_SLV;
    end else begin
      addrKind = K_DEF;
    end
  end

  always_comb begin
    out_sl_HSEL = '0;
    for (int i = 0; i < N_SLAVE; i++) begin
      out_sl_HSEL[i] = active & hitAny & (winIdx == IDX_W'(i));
    end
  end

  // The default slave only ever owns the data phase while the FSM is in
  // D_ERR1 or D_ERR2; the wait state is the D_ERR1 cycle.
  always_comb begin
    rspReady = 1'b1;
    rspResp  = RESP_OKAY;
    rspData  = '0;
    case (dpKind_q)
      K_SLV: begin
        for (int i = 0; i < N_SLAVE; i++) begin
          if (dpIdx_q == IDX_W'(i)) begin
            rspReady = sl_HREADY[i];
            rspResp  = sl_HRESP[i*2 +: 2];
            rspData  = sl_HRDATA[i*W_DATA +: W_DATA];
          end
        end
      end
      K_DEF: begin
        rspReady = (defState_q != D_ERR1);
        rspResp  = RESP_ERROR;
      end
      default: begin
      end
    endcase
  end

  assign loadDef = rspReady & (addrKind == K_DEF);

  // Next state: data-phase owner, default-slave FSM and error log. An err_clr
  // is applied after the increment so it wins, while the address is kept.
  always_comb begin
    dpKind_d   = dpKind_q;
    dpIdx_d    = dpIdx_q;
    defState_d = defState_q;
    errCnt_d   = errCnt_q;
    errAddr_d  = errAddr_q;

    if (rspReady) begin
      dpKind_d = addrKind;
      dpIdx_d  = winIdx;
    end

    case (defState_q)
      D_ERR1: defState_d = D_ERR2;
      default: begin
        if (rspReady) begin
          defState_d = loadDef ? D_ERR1 : D_IDLE;
        end
      end
    endcase

    if (loadDef) begin
      errAddr_d = ma_HADDR;
      if (errCnt_q != '1) begin
        errCnt_d = errCnt_q + W_ERRCNT'(1);
      end
    end
    if (err_clr) begin
      errCnt_d = '0;
    end
  end

  // State registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dpKind_q   <= K_NONE;
      dpIdx_q    <= '0;
      defState_q <= D_IDLE;
      errCnt_q   <= '0;
      errAddr_q  <= '0;
    end else begin
      dpKind_q   <= dpKind_d;
      dpIdx_q    <= dpIdx_d;
      defState_q <= defState_d;
      errCnt_q   <= errCnt_d;
      errAddr_q  <= errAddr_d;
    end
  end

  assign out_ma_HREADY = rspReady;
  assign out_ma_HRESP  = rspResp;
  assign out_ma_HRDATA = rspData;
  assign out_sl_HREADY = rspReady;

  assign out_sl_HADDR  = ma_HADDR;
  assign out_sl_HTRANS = ma_HTRANS;
  assign out_sl_HWRITE = ma_HWRITE;
  assign out_sl_HSIZE  = ma_HSIZE;
  assign out_sl_HBURST = ma_HBURST;
  assign out_sl_HWDATA = ma_HWDATA;

  assign err_cnt  = errCnt_q;
  assign err_addr = errAddr_q;

endmodule
